// File: rtl/fifo_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the round-robin FIFO controller.
package fifo_ctrl_pkg;

    localparam int          PKG_DATA_W          = 10;
    localparam int          PKG_N_SRC           = 4;
    localparam int          PTR_W               = 2;
    localparam logic [7:0]  PKG_UMBRAL_BAJO_RST = 8'd1;
    localparam logic [7:0]  PKG_UMBRAL_ALTO_RST = 8'd5;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [PKG_N_SRC-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < PKG_N_SRC; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Four-way round-robin arbiter: searches upward from pointer+1, pointer moves to the winner
// only when adv_i is asserted.
module rr_arbiter
    import fifo_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PKG_N_SRC-1:0] req_i,
    input  logic                 adv_i,
    output logic [PKG_N_SRC-1:0] gnt_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d, idx;
    logic             found;

    // k = N_SRC wraps to the pointer itself, so the last holder is checked last
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= PKG_N_SRC; k++) begin
            idx = ptr_q + PTR_W'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = onehot_to_idx(gnt_o);
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '1;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Sequences four source FIFOs into one destination FIFO and forwards the FIFO thresholds.
// Define FIFO_ERR_STICKY_EN to make ERROR exit only through reset.
module fifo_rr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int         DATA_W          = PKG_DATA_W,
    parameter int         N_SRC           = PKG_N_SRC,
    parameter logic [7:0] UMBRAL_BAJO_RST = PKG_UMBRAL_BAJO_RST,
    parameter logic [7:0] UMBRAL_ALTO_RST = PKG_UMBRAL_ALTO_RST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [7:0]              umbral_bajo_in,
    input  logic [7:0]              umbral_alto_in,
    input  logic [N_SRC-1:0]        src_empty,
    input  logic [N_SRC-1:0]        src_error,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    dst_almost_full,
    input  logic                    dst_error,
    output logic [N_SRC-1:0]        pop,
    output logic                    push,
    output logic [DATA_W-1:0]       data_out,
    output logic [7:0]              umbral_bajo,
    output logic [7:0]              umbral_alto,
    output logic [2:0]              state,
    output logic                    idle,
    output logic                    error_out
);

    state_e              state_q, state_d;
    logic [N_SRC-1:0]    pop_q, gnt, req;
    logic                push_q, any_err, any_data, grant_ok, adv;
    logic [DATA_W-1:0]   data_q, sel_data;
    logic [7:0]          ubajo_q, ualto_q;

    assign any_err  = (|src_error) | dst_error;
    assign any_data = |(~src_empty);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (any_err)       state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (any_data) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (any_err)   state_d = ST_ERROR;
                else if (init) state_d = ST_INIT;
                else if (!any_data && !(|pop_q) && !push_q) state_d = ST_IDLE;
            end
            ST_ERROR: begin
`ifdef FIFO_ERR_STICKY_EN
                state_d = ST_ERROR;
`else
                if (!any_err) state_d = ST_IDLE;
`endif
            end
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        idle      = (state_q == ST_IDLE);
        error_out = (state_q == ST_ERROR);
        state     = state_q;
    end

    // A source popped last edge still shows its old empty flag, so it sits this one out
    assign grant_ok = (state_q == ST_ACTIVE) && !dst_almost_full && !any_err && !init;
    assign req      = ~src_empty & ~pop_q & {N_SRC{grant_ok}};
    assign adv      = |gnt;

    rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .adv_i (adv),
        .gnt_o (gnt)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pop_q[i]) sel_data = src_data[i*DATA_W +: DATA_W];
        end
    end

    // pop -> push/data stage; an issued pop always completes its push
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q  <= '0;
            push_q <= 1'b0;
            data_q <= '0;
        end else begin
            pop_q  <= gnt;
            push_q <= |pop_q;
            if (|pop_q) data_q <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ubajo_q <= UMBRAL_BAJO_RST;
            ualto_q <= UMBRAL_ALTO_RST;
        end else if (state_q == ST_INIT) begin
            ubajo_q <= umbral_bajo_in;
            ualto_q <= umbral_alto_in;
        end
    end

    assign pop         = pop_q;
    assign push        = push_q;
    assign data_out    = data_q;
    assign umbral_bajo = ubajo_q;
    assign umbral_alto = ualto_q;

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Directed bench for fifo_rr_ctrl with a behavioural model of the four show-ahead source FIFOs.
module tb_fifo_rr_ctrl;

    localparam int DW = 10;
    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           reset, init, dst_almost_full, dst_error;
    logic [7:0]     umbral_bajo_in, umbral_alto_in;
    logic [NS-1:0]  src_empty, src_error;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]  pop;
    logic           push, idle, error_out;
    logic [DW-1:0]  data_out;
    logic [7:0]     umbral_bajo, umbral_alto;
    logic [2:0]     state;

    int             cnt [NS];
    logic [7:0]     rd  [NS];
    int             n_chk = 0;
    int             n_err = 0;

    logic [3:0]     exp_pop4 [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    logic [9:0]     exp_dat4 [5] = '{10'h000, 10'h100, 10'h200, 10'h300, 10'h001};
    logic [3:0]     exp_pop1 [7] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0};
    logic           exp_psh1 [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]     exp_dat1 [7] = '{10'h0, 10'h202, 10'h0, 10'h203, 10'h0, 10'h204, 10'h0};

    fifo_rr_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_bajo_in  (umbral_bajo_in),
        .umbral_alto_in  (umbral_alto_in),
        .src_empty       (src_empty),
        .src_error       (src_error),
        .src_data        (src_data),
        .dst_almost_full (dst_almost_full),
        .dst_error       (dst_error),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .umbral_bajo     (umbral_bajo),
        .umbral_alto     (umbral_alto),
        .state           (state),
        .idle            (idle),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Source word = {source index, read pointer}; the head is visible before it is popped
    task automatic drive_src();
        for (int i = 0; i < NS; i++) begin
            src_empty[i] = (cnt[i] == 0);
            src_data[i*DW +: DW] = DW'((i << 8) | int'(rd[i]));
        end
    endtask

    task automatic step();
        logic [NS-1:0] pp;
        pp = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (pp[i] === 1'b1 && cnt[i] > 0) begin
                cnt[i]--;
                rd[i]++;
            end
        end
        drive_src();
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; dst_almost_full = 1'b0; dst_error = 1'b0;
        umbral_bajo_in = 8'd0; umbral_alto_in = 8'd0; src_error = '0;
        for (int i = 0; i < NS; i++) begin cnt[i] = 0; rd[i] = 8'd0; end
        drive_src();
        step(); step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ubajo", 32'(umbral_bajo), 32'd1);
        chk("rst_ualto", 32'(umbral_alto), 32'd5);
        chk("rst_idle", 32'(idle), 32'd0);
        chk("rst_err", 32'(error_out), 32'd0);

        reset = 1'b0; init = 1'b1; umbral_bajo_in = 8'd2; umbral_alto_in = 8'd6;
        step();
        chk("init_state", 32'(state), 32'd1);
        step();
        chk("init_ubajo", 32'(umbral_bajo), 32'd2);
        chk("init_ualto", 32'(umbral_alto), 32'd6);
        step();
        init = 1'b0;
        step();
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_flag", 32'(idle), 32'd1);
        chk("idle_ualto", 32'(umbral_alto), 32'd6);

        for (int i = 0; i < NS; i++) cnt[i] = 2;
        drive_src();
        step();
        chk("act_state", 32'(state), 32'd3);
        chk("act_pop0", 32'(pop), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr4_pop", 32'(pop), 32'(exp_pop4[k]));
            if (k == 0) chk("rr4_push0", 32'(push), 32'd0);
            else begin
                chk("rr4_push", 32'(push), 32'd1);
                chk("rr4_data", 32'(data_out), 32'(exp_dat4[k-1]));
            end
        end

        dst_almost_full = 1'b1;
        step();
        chk("af_pop", 32'(pop), 32'd0);
        chk("af_trail_push", 32'(push), 32'd1);
        chk("af_trail_data", 32'(data_out), 32'h101);
        step();
        chk("af_pop2", 32'(pop), 32'd0);
        chk("af_push2", 32'(push), 32'd0);
        dst_almost_full = 1'b0;
        step();
        chk("af_resume_pop", 32'(pop), 32'h4);
        step();
        chk("af_pop_s3", 32'(pop), 32'h8);
        chk("af_data_s2", 32'(data_out), 32'h201);
        step();
        chk("drain_pop", 32'(pop), 32'd0);
        chk("drain_data", 32'(data_out), 32'h301);
        step();
        chk("drain_push", 32'(push), 32'd0);
        chk("drain_state", 32'(state), 32'd3);
        step();
        chk("drain_idle", 32'(state), 32'd2);

        cnt[2] = 3;
        drive_src();
        step();
        chk("one_act", 32'(state), 32'd3);
        for (int k = 0; k < 7; k++) begin
            step();
            chk("one_pop", 32'(pop), 32'(exp_pop1[k]));
            chk("one_push", 32'(push), 32'(exp_psh1[k]));
            if (exp_psh1[k]) chk("one_data", 32'(data_out), 32'(exp_dat1[k]));
        end
        chk("one_still_act", 32'(state), 32'd3);
        step();
        chk("one_idle", 32'(state), 32'd2);

        cnt[1] = 2; cnt[3] = 2;
        drive_src();
        step();
        chk("err_act", 32'(state), 32'd3);
        step();
        chk("err_pre_pop", 32'(pop), 32'h8);
        src_error = 4'b0010;
        step();
        chk("err_state", 32'(state), 32'd4);
        chk("err_flag", 32'(error_out), 32'd1);
        chk("err_pop", 32'(pop), 32'd0);
        chk("err_push", 32'(push), 32'd1);
        chk("err_data", 32'(data_out), 32'h302);
        src_error = '0;
        step();
`ifdef FIFO_ERR_STICKY_EN
        chk("sticky_state", 32'(state), 32'd4);
        step();
        chk("sticky_state2", 32'(state), 32'd4);
        chk("sticky_pop", 32'(pop), 32'd0);
`else
        chk("recov_state", 32'(state), 32'd2);
        chk("recov_idle", 32'(idle), 32'd1);
        chk("recov_errflag", 32'(error_out), 32'd0);
`endif

        reset = 1'b1;
        step();
        reset = 1'b0; init = 1'b1; umbral_bajo_in = 8'd3; umbral_alto_in = 8'd4;
        step();
        step();
        init = 1'b0;
        step();
        chk("re_idle", 32'(state), 32'd2);
        chk("re_ubajo", 32'(umbral_bajo), 32'd3);
        chk("re_ualto", 32'(umbral_alto), 32'd4);
        for (int i = 0; i < NS; i++) cnt[i] = 4;
        drive_src();
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("re_pop", 32'(pop), 32'(exp_pop4[k]));
        end
        reset = 1'b1;
        step();
        chk("mid_rst_pop", 32'(pop), 32'd0);
        chk("mid_rst_push", 32'(push), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_ubajo", 32'(umbral_bajo), 32'd1);
        chk("mid_rst_ualto", 32'(umbral_alto), 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
